// File: rtl/ram_prog_pkg.sv
// Shared types and defaults for the UART program loader.
// The PROG_CHECKSUM_EN macro adds the CKSUM state to the loader FSM.
package ram_prog_pkg;

  localparam int unsigned CLK_DIV_DEF        = 434;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 50_000_000;
  localparam logic [31:0] PROG_SEQ_DEF       = 32'h54454B4E;
  localparam int unsigned BLOCK_SIZE_DEF     = 128;

  // Bytes carried by one RAM line.
  function automatic int unsigned nums_byte(input int unsigned block_size);
    return block_size / 8;
  endfunction

`ifdef PROG_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_LEN, ST_DATA, ST_FLUSH, ST_CKSUM, ST_DONE
  } prog_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_LEN, ST_DATA, ST_FLUSH, ST_DONE
  } prog_state_e;
`endif

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT
  } rx_state_e;

endpackage

// File: rtl/ram_prog_loader_uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, glitch-rejecting
// start detection, and a frame-error pulse on a low stop bit.
module prog_uart_rx
  import ram_prog_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic       rx_valid_o,
  output logic [7:0] rx_data_o,
  output logic       frame_err_o
);
  localparam int unsigned   CW      = $clog2(CLK_DIV);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLK_DIV - 1);

  logic          rx_s1, rx_s2;
  rx_state_e     st_q, st_d;
  logic [CW-1:0] tick_q;
  logic [2:0]    bit_q;
  logic [7:0]    shr_q;
  logic          tick_half, tick_full;

  assign tick_half = (tick_q == HALF_M1);
  assign tick_full = (tick_q == FULL_M1);

  // Bring the asynchronous line into the clock domain; idles high.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx_i;
      rx_s2 <= rx_s1;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) st_q <= RX_IDLE;
    else         st_q <= st_d;
  end

  // Frame sequencing; after a bad stop bit wait for the line to go high.
  always_comb begin
    st_d = st_q;
    case (st_q)
      RX_IDLE:  if (!rx_s2) st_d = RX_START;
      RX_START: if (tick_half) st_d = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick_full && bit_q == 3'd7) st_d = RX_STOP;
      RX_STOP:  if (tick_full) st_d = rx_s2 ? RX_IDLE : RX_WAIT;
      RX_WAIT:  if (rx_s2) st_d = RX_IDLE;
      default:  st_d = RX_IDLE;
    endcase
  end

  // Bit timer, LSB-first shift register and delivery pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick_q      <= '0;
      bit_q       <= '0;
      shr_q       <= '0;
      rx_valid_o  <= 1'b0;
      rx_data_o   <= '0;
      frame_err_o <= 1'b0;
    end else begin
      rx_valid_o  <= 1'b0;
      frame_err_o <= 1'b0;
      tick_q      <= (st_d != st_q || tick_full) ? '0 : tick_q + 1'b1;
      if (st_q == RX_START) bit_q <= '0;
      if (st_q == RX_DATA && tick_full) begin
        shr_q <= {rx_s2, shr_q[7:1]};
        bit_q <= bit_q + 1'b1;
      end
      if (st_q == RX_STOP && tick_full) begin
        if (rx_s2) begin
          rx_valid_o <= 1'b1;
          rx_data_o  <= shr_q;
        end else begin
          frame_err_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ram_prog_loader.sv
// UART program loader: waits for the magic word, reads a little-endian
// length, packs payload bytes into RAM lines and holds the core in reset
// for the duration. Define PROG_CHECKSUM_EN to require a trailing XOR byte.
module ram_prog_loader
  import ram_prog_pkg::*;
#(
  parameter int unsigned CLK_DIV        = CLK_DIV_DEF,
  parameter int unsigned BLOCK_SIZE     = BLOCK_SIZE_DEF,
  parameter int unsigned NUMS_BYTE      = nums_byte(BLOCK_SIZE),
  parameter int unsigned RAM_DEPTH      = 8192,
  parameter int unsigned ADDR_W         = $clog2(RAM_DEPTH),
  parameter logic [31:0] PROG_SEQ       = PROG_SEQ_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  prog_rx_i,
  output logic                  prog_we_o,
  output logic [ADDR_W-1:0]     prog_addr_o,
  output logic [BLOCK_SIZE-1:0] prog_wdata_o,
  output logic [NUMS_BYTE-1:0]  prog_wstrb_o,
  output logic                  system_reset_o,
  output logic                  prog_mode_led_o,
  output logic                  prog_err_o
);
  localparam int unsigned LANE_W = $clog2(NUMS_BYTE);

  prog_state_e           state_q, state_d;
  logic                  rx_valid, frame_err;
  logic [7:0]            rx_data;
  logic [1:0]            hdr_cnt_q;
  logic [31:0]           len_q, byte_cnt_q, line_idx_q, idle_cnt_q;
  logic [BLOCK_SIZE-1:0] line_q, line_merged;
  logic [NUMS_BYTE-1:0]  strb_q, strb_merged;
  logic                  ovf_q, sys_rst_q;
  logic [LANE_W-1:0]     lane;
  logic [7:0]            seq_byte;
  logic [31:0]           len_full;
  logic                  last_byte, line_done, in_ovf, active, timeout;
`ifdef PROG_CHECKSUM_EN
  logic [7:0]            xor_q;
  logic                  ck_fail_q;
`endif

  prog_uart_rx #(.CLK_DIV(CLK_DIV)) u_rx (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .rx_i        (prog_rx_i),
    .rx_valid_o  (rx_valid),
    .rx_data_o   (rx_data),
    .frame_err_o (frame_err)
  );

  // Per-byte decode: lane merge, magic byte select, end-of-line/load tests.
  always_comb begin
    lane        = byte_cnt_q[LANE_W-1:0];
    line_merged = line_q;
    line_merged[{lane, 3'b000} +: 8] = rx_data;
    strb_merged = strb_q | (NUMS_BYTE'(1) << lane);
    seq_byte    = 8'(PROG_SEQ >> {~hdr_cnt_q, 3'b000});
    len_full    = {rx_data, len_q[31:8]};
    last_byte   = ((byte_cnt_q + 32'd1) == len_q);
    line_done   = (&lane) || last_byte;
    in_ovf      = (line_idx_q >= 32'(RAM_DEPTH));
`ifdef PROG_CHECKSUM_EN
    active      = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CKSUM);
`else
    active      = (state_q == ST_LEN) || (state_q == ST_DATA);
`endif
    timeout     = active && !rx_valid && (idle_cnt_q >= 32'(TIMEOUT_CYCLES));
  end

  // Loader state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Loader sequencing; a timeout aborts any active phase.
  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (rx_valid && hdr_cnt_q == 2'd3 && rx_data == seq_byte) state_d = ST_LEN;
        ST_LEN:   if (rx_valid && hdr_cnt_q == 2'd3) state_d = (len_full == 32'd0) ? ST_DONE : ST_DATA;
        ST_DATA:  if (rx_valid && last_byte) state_d = ST_FLUSH;
`ifdef PROG_CHECKSUM_EN
        ST_FLUSH: state_d = ST_CKSUM;
        ST_CKSUM: if (rx_valid) state_d = (rx_data == xor_q) ? ST_DONE : ST_IDLE;
`else
        ST_FLUSH: state_d = ST_DONE;
`endif
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Header/line assembly, write stage, core reset and error pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hdr_cnt_q    <= '0;
      len_q        <= '0;
      byte_cnt_q   <= '0;
      line_idx_q   <= '0;
      idle_cnt_q   <= '0;
      line_q       <= '0;
      strb_q       <= '0;
      ovf_q        <= 1'b0;
      sys_rst_q    <= 1'b1;
      prog_we_o    <= 1'b0;
      prog_addr_o  <= '0;
      prog_wdata_o <= '0;
      prog_wstrb_o <= '0;
      prog_err_o   <= 1'b0;
`ifdef PROG_CHECKSUM_EN
      xor_q        <= '0;
      ck_fail_q    <= 1'b0;
`endif
    end else begin
      prog_we_o  <= 1'b0;
      prog_err_o <= frame_err || timeout;
      idle_cnt_q <= (rx_valid || !active) ? 32'd0 : idle_cnt_q + 32'd1;
      case (state_q)
        ST_IDLE: begin
          if (rx_valid) begin
            if (rx_data == seq_byte) begin
              hdr_cnt_q <= hdr_cnt_q + 2'd1;
              if (hdr_cnt_q == 2'd3) begin
                sys_rst_q  <= 1'b0;
                len_q      <= '0;
                byte_cnt_q <= '0;
                line_idx_q <= '0;
                line_q     <= '0;
                strb_q     <= '0;
                ovf_q      <= 1'b0;
`ifdef PROG_CHECKSUM_EN
                xor_q      <= '0;
`endif
              end
            end else begin
              hdr_cnt_q <= (rx_data == PROG_SEQ[31:24]) ? 2'd1 : 2'd0;
            end
          end
        end
        ST_LEN: begin
          if (rx_valid) begin
            len_q     <= len_full;
            hdr_cnt_q <= hdr_cnt_q + 2'd1;
          end
        end
        ST_DATA: begin
          if (rx_valid) begin
            byte_cnt_q <= byte_cnt_q + 32'd1;
`ifdef PROG_CHECKSUM_EN
            xor_q      <= xor_q ^ rx_data;
`endif
            if (line_done) begin
              prog_we_o    <= !in_ovf;
              prog_addr_o  <= line_idx_q[ADDR_W-1:0];
              prog_wdata_o <= line_merged;
              prog_wstrb_o <= strb_merged;
              line_idx_q   <= line_idx_q + 32'd1;
              line_q       <= '0;
              strb_q       <= '0;
              if (in_ovf && !ovf_q) begin
                ovf_q      <= 1'b1;
                prog_err_o <= 1'b1;
              end
            end else begin
              line_q <= line_merged;
              strb_q <= strb_merged;
            end
          end
        end
`ifdef PROG_CHECKSUM_EN
        ST_CKSUM: begin
          if (rx_valid && rx_data != xor_q) begin
            prog_err_o <= 1'b1;
            ck_fail_q  <= 1'b1;
          end
        end
`endif
        ST_DONE: begin
          sys_rst_q <= 1'b1;
`ifdef PROG_CHECKSUM_EN
          ck_fail_q <= 1'b0;
`endif
        end
        default: ;
      endcase
      if (timeout) begin
        sys_rst_q <= 1'b1;
        hdr_cnt_q <= '0;
        line_q    <= '0;
        strb_q    <= '0;
      end
    end
  end

  assign system_reset_o = sys_rst_q;
`ifdef PROG_CHECKSUM_EN
  assign prog_mode_led_o = (state_q != ST_IDLE) || ck_fail_q;
`else
  assign prog_mode_led_o = (state_q != ST_IDLE);
`endif

endmodule

// File: tb/tb_ram_prog_loader.sv
// Self-checking bench for ram_prog_loader with shortened UART/timeout timing
// and a 4-line RAM so overflow is reachable.
module tb_ram_prog_loader;
  localparam int unsigned CLK_DIV = 16;
  localparam int unsigned BS      = 128;
  localparam int unsigned NB      = 16;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned AW      = 2;
  localparam int unsigned TO      = 600;
  localparam logic [31:0] MAGIC   = 32'h54454B4E;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          prog_rx = 1'b1;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [BS-1:0] prog_wdata;
  logic [NB-1:0] prog_wstrb;
  logic          system_reset;
  logic          prog_mode_led;
  logic          prog_err;

  ram_prog_loader #(
    .CLK_DIV(CLK_DIV), .BLOCK_SIZE(BS), .NUMS_BYTE(NB), .RAM_DEPTH(DEPTH),
    .ADDR_W(AW), .PROG_SEQ(MAGIC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .prog_rx_i       (prog_rx),
    .prog_we_o       (prog_we),
    .prog_addr_o     (prog_addr),
    .prog_wdata_o    (prog_wdata),
    .prog_wstrb_o    (prog_wstrb),
    .system_reset_o  (system_reset),
    .prog_mode_led_o (prog_mode_led),
    .prog_err_o      (prog_err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Observed activity since the last clear_mon().
  logic [AW-1:0] ga[$];
  logic [BS-1:0] gd[$];
  logic [NB-1:0] gs[$];
  int err_cnt = 0;
  int rst_low_cyc = 0;
  int led_cyc = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (prog_we) begin
        ga.push_back(prog_addr);
        gd.push_back(prog_wdata);
        gs.push_back(prog_wstrb);
      end
      if (prog_err) err_cnt++;
      if (!system_reset) rst_low_cyc++;
      if (prog_mode_led) led_cyc++;
    end
  end

  logic [7:0] payload[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    prog_rx = 1'b0;
    cyc(CLK_DIV);
    for (int i = 0; i < 8; i++) begin
      prog_rx = b[i];
      cyc(CLK_DIV);
    end
    prog_rx = stop;
    cyc(CLK_DIV);
    prog_rx = 1'b1;
    cyc(CLK_DIV * (1 + $urandom_range(0, 1)));
  endtask

  task automatic send_magic();
    logic [31:0] m;
    m = MAGIC;
    for (int i = 0; i < 4; i++) send_byte(m[31 - 8*i -: 8], 1'b1);
  endtask

  task automatic send_len(input logic [31:0] len);
    for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8], 1'b1);
  endtask

  task automatic clear_mon();
    ga.delete();
    gd.delete();
    gs.delete();
    err_cnt = 0;
    rst_low_cyc = 0;
    led_cyc = 0;
  endtask

  // Send one complete load of payload[] and compare against the line model:
  // line i holds payload[16i .. 16i+15], byte k at bits [8k+7:8k], one strobe
  // per present byte; lines at or beyond DEPTH are dropped with one error.
  task automatic run_load(input string tag);
    int n, nl, nw, exp_err;
    logic [BS-1:0] ed;
    logic [NB-1:0] es;
    logic [7:0] x;
    n = payload.size();
    x = 8'h00;
    send_magic();
    check({tag, "_rst_low_after_magic"}, 128'(system_reset), 128'(0));
    check({tag, "_led_after_magic"}, 128'(prog_mode_led), 128'(1));
    send_len(32'(n));
    foreach (payload[i]) begin
      send_byte(payload[i], 1'b1);
      x = x ^ payload[i];
    end
`ifdef PROG_CHECKSUM_EN
    if (n > 0) send_byte(x, 1'b1);
`endif
    cyc(40);
    nl = (n + 15) / 16;
    nw = (nl > int'(DEPTH)) ? int'(DEPTH) : nl;
    exp_err = (nl > int'(DEPTH)) ? 1 : 0;
    check({tag, "_nwrites"}, 128'(ga.size()), 128'(nw));
    for (int i = 0; i < nw && i < ga.size(); i++) begin
      ed = '0;
      es = '0;
      for (int k = 0; k < int'(NB); k++) begin
        if (16*i + k < n) begin
          ed[8*k +: 8] = payload[16*i + k];
          es[k] = 1'b1;
        end
      end
      check($sformatf("%s_addr%0d", tag, i), 128'(ga[i]), 128'(i));
      check($sformatf("%s_data%0d", tag, i), 128'(gd[i]), 128'(ed));
      check($sformatf("%s_strb%0d", tag, i), 128'(gs[i]), 128'(es));
    end
    check({tag, "_err"}, 128'(err_cnt), 128'(exp_err));
    check({tag, "_sysrst_end"}, 128'(system_reset), 128'(1));
    check({tag, "_led_end"}, 128'(prog_mode_led), 128'(0));
    check({tag, "_rst_was_held"}, 128'(rst_low_cyc > 0), 128'(1));
  endtask

  initial begin
    // Reset values
    cyc(3);
    check("rst_we", 128'(prog_we), 128'(0));
    check("rst_addr", 128'(prog_addr), 128'(0));
    check("rst_wdata", 128'(prog_wdata), 128'(0));
    check("rst_wstrb", 128'(prog_wstrb), 128'(0));
    check("rst_sysrst", 128'(system_reset), 128'(1));
    check("rst_led", 128'(prog_mode_led), 128'(0));
    check("rst_err", 128'(prog_err), 128'(0));
    rst_n = 1'b1;
    cyc(5);

    // Two full lines 00..1F
    clear_mon();
    payload.delete();
    for (int i = 0; i < 32; i++) payload.push_back(8'(i));
    run_load("two_lines");

    // Partial line of five bytes
    clear_mon();
    payload = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    run_load("partial");

    // "TTEKN" then zero length
    clear_mon();
    send_byte(8'h54, 1'b1);
    payload.delete();
    run_load("ttekn_len0");
    check("ttekn_led_pulsed", 128'(led_cyc > 0), 128'(1));

    // Timeout during payload
    clear_mon();
    send_magic();
    send_len(32'd16);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b1);
    check("to_led_mid", 128'(prog_mode_led), 128'(1));
    cyc(1000);
    check("to_err", 128'(err_cnt), 128'(1));
    check("to_nwrites", 128'(ga.size()), 128'(0));
    check("to_sysrst", 128'(system_reset), 128'(1));
    check("to_led", 128'(prog_mode_led), 128'(0));

    // Framing error in IDLE
    clear_mon();
    send_byte(8'h54, 1'b0);
    cyc(20);
    check("fe_err", 128'(err_cnt), 128'(1));
    check("fe_nwrites", 128'(ga.size()), 128'(0));
    check("fe_led", 128'(led_cyc), 128'(0));
    check("fe_sysrst", 128'(rst_low_cyc), 128'(0));

    // Overflow: five lines into a four-line RAM
    clear_mon();
    payload.delete();
    for (int i = 0; i < 70; i++) payload.push_back(8'($urandom));
    run_load("overflow");

    // Randomized loads
    for (int r = 0; r < 3; r++) begin
      clear_mon();
      payload.delete();
      for (int i = 0; i < int'($urandom_range(1, 24)); i++) payload.push_back(8'($urandom));
      run_load($sformatf("rand%0d", r));
    end

`ifdef PROG_CHECKSUM_EN
    // Good checksum
    clear_mon();
    payload = '{8'h12, 8'h34};
    run_load("ck_good");
    // Bad checksum keeps the core in reset and the LED on
    clear_mon();
    send_magic();
    send_len(32'd2);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h00, 1'b1);
    cyc(40);
    check("ck_bad_err", 128'(err_cnt), 128'(1));
    check("ck_bad_sysrst", 128'(system_reset), 128'(0));
    check("ck_bad_led", 128'(prog_mode_led), 128'(1));
    // A later good load releases the core
    clear_mon();
    payload = '{8'h01, 8'h02, 8'h03};
    run_load("ck_recover");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ram_prog_loader.md
Name: ram_prog_loader

Overview:
- UART program loader directly upstream of the main-memory RAM write port.
- Listens on the dedicated program-RX pin for a 4-byte magic sequence, a 32-bit length, then the payload bytes.
- Packs payload bytes into BLOCK_SIZE-bit lines and issues strobed line writes to the RAM.
- Holds the core in reset (active-low system_reset_o) for the whole load, then releases it.

Parameters:
- CLK_DIV, 434, clock cycles per UART bit (50 MHz / 115200).
- BLOCK_SIZE, 128, RAM line width in bits.
- NUMS_BYTE, BLOCK_SIZE/8, bytes per line.
- RAM_DEPTH, 8192, lines in the RAM.
- ADDR_W, $clog2(RAM_DEPTH), line address width.
- PROG_SEQ, 32'h54454B4E, magic sequence ("TEKN"), received MSB byte first.
- TIMEOUT_CYCLES, 50_000_000, maximum idle gap between bytes once the magic has matched.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- prog_rx_i  in  1  UART serial input, idle high, asynchronous to clk_i
- prog_we_o  out  1  one-cycle RAM line write pulse
- prog_addr_o  out  ADDR_W  line address
- prog_wdata_o  out  BLOCK_SIZE  line data; byte k at bits [8k+7:8k]
- prog_wstrb_o  out  NUMS_BYTE  byte strobes
- system_reset_o  out  1  active-low core reset; 0 while loading
- prog_mode_led_o  out  1  high while not in IDLE
- prog_err_o  out  1  one-cycle error pulse

Behaviour:
- Reset (async, rst_ni low): state IDLE; all outputs 0 except system_reset_o=1. Shift/line registers, counters and RX synchroniser cleared; sync flops reset to 1.
- UART RX:
  - prog_rx_i passes through a 2-flop synchroniser.
  - A falling edge arms a start bit; the line is re-sampled at CLK_DIV/2. If it is high there, the start is discarded as a glitch.
  - 8 data bits LSB first, each sampled at CLK_DIV intervals; stop bit sampled one interval later.
  - Stop=1: rx_valid pulses one cycle, byte delivered.
  - Stop=0: byte dropped, prog_err_o pulses; RX waits for the line to return high before re-arming.
- FSM states: IDLE, LEN, DATA, FLUSH, CKSUM, DONE.
- IDLE: compares incoming bytes against PROG_SEQ.
  - Mismatch restarts matching; the mismatching byte is re-tested as first byte ("TTEKN" matches).
  - Full match → LEN; system_reset_o←0 on that cycle.
- LEN: 4 bytes, little-endian, into len_q (32-bit).
  - len_q==0 → DONE.
  - Otherwise → DATA.
- DATA: each byte goes into byte lane byte_cnt[log2 NUMS_BYTE-1:0] of the line register.
  - Strobe bit set for that lane; the 32-bit byte_cnt increments.
  - When lane NUMS_BYTE-1 is filled, or byte_cnt reaches len_q: the next cycle drives prog_we_o=1 with addr=line_idx, then line_idx++ and the line register and strobes clear.
  - A partial final line writes only the received lanes; the others hold 0 data and 0 strobe.
  - After the last byte's write → CKSUM if the feature is enabled, else DONE.
- Overflow: lines with line_idx ≥ RAM_DEPTH are not written (prog_we_o suppressed); bytes are still consumed; prog_err_o pulses once at the first suppressed line.
- DONE: system_reset_o←1 one cycle after entry; → IDLE.
- Timeout: in LEN/DATA/CKSUM, a gap > TIMEOUT_CYCLES with no rx_valid:
  - prog_err_o pulse; → IDLE.
  - A pending partial line is discarded.
  - system_reset_o←1.
- A new rx_valid in the same cycle as a write pulse is accepted (the line register is double-buffered by the write-stage register); no byte is lost at line boundaries.
- prog_addr_o, prog_wdata_o and prog_wstrb_o are registered and meaningful only while prog_we_o=1.

Optional Feature:
- PROG_CHECKSUM_EN defined:
  - After the payload, state CKSUM receives 1 byte, the expected XOR of all payload bytes.
  - Match → DONE.
  - Mismatch → prog_err_o pulse; → IDLE with system_reset_o held 0 and the LED kept on until a later load completes successfully.
- Undefined: no CKSUM state; DATA → DONE directly; no checksum logic.

Decomposition:
- Package ram_prog_pkg holds:
  - the state enum;
  - default PROG_SEQ, CLK_DIV and TIMEOUT_CYCLES constants;
  - the BLOCK_SIZE/NUMS_BYTE derivation.
- Sub-module prog_uart_rx (synchroniser, bit timer, shift register, rx_valid/rx_data/frame_err) is instantiated once.

Test Plan:
- Send 54 45 4B 4E, len 20 00 00 00, bytes 00..1F → two writes: addr 0 data 0F..00 (byte0 at LSB) strobe FFFF, addr 1 data 1F..10 strobe FFFF; system_reset_o low from magic until one cycle after DONE.
- Length 5, bytes AA BB CC DD EE → single write addr 0, wstrb 001F, data[39:0]=EE_DD_CC_BB_AA, upper bits 0.
- Stream 54 54 45 4B 4E then length 0 → match on the second 'T'; no writes; system_reset_o pulses low and returns to 1; LED pulses.
- Start length 16, send 3 bytes, then idle > TIMEOUT_CYCLES → prog_err_o pulse, no write, back to IDLE, system_reset_o=1.
- Byte with stop bit forced 0 while in IDLE → prog_err_o pulse, byte dropped, no state change.
- With PROG_CHECKSUM_EN: len 2, bytes 12 34, checksum 26 → DONE, reset released. Repeat with checksum 00 → err pulse, system_reset_o stays 0.
